// File: rtl/ms_alarm_timer.sv
// ms_alarm_timer: millisecond alarm timer with a small register file.
// Counts ticks derived from an upstream ms counter and raises a level irq.
//
// Ports:
//   clk    - single clock, all state updates on its rising edge
//   rst    - synchronous active-high reset
//   ms_in  - free-running millisecond count from the upstream counter
//   wr_en  - register write strobe
//   addr   - register address, shared by reads and writes
//   wdata  - write data
//   rdata  - registered read data, addressed register one cycle later
//   irq    - level interrupt, fired AND irq_en, registered
//
// Register map:
//   0 CTRL    bit0 en, bit1 periodic, bit2 irq_en
//   1 PERIOD  32-bit reload value (0 behaves as 1)
//   2 STATUS  bit0 fired (write 1 to clear), bit1 busy (read-only)
//   3 REMAIN  read-only countdown value
//   4 CAPTURE read-only ms_in sampled on FIRE (only with the macro)
//   5-7       read 0, writes ignored
//
// Build option: define MS_ALARM_CAPTURE_EN to implement CAPTURE.
// Without it, address 4 reads 0.

module ms_alarm_timer #(
    parameter logic [31:0] RESET_PERIOD = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ms_in,
    input  logic        wr_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_PERIOD  = 3'd1;
    localparam logic [2:0] A_STATUS  = 3'd2;
    localparam logic [2:0] A_REMAIN  = 3'd3;
    localparam logic [2:0] A_CAPTURE = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_periodic;
    logic        ctrl_irq_en;
    logic [31:0] period;
    logic        fired;
    logic [31:0] remain;
    logic [31:0] ms_prev;

`ifdef MS_ALARM_CAPTURE_EN
    logic [31:0] capture;
`endif

    logic        tick;
    logic        busy;
    logic [31:0] load_val;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_status;
    logic        fired_d;
    logic        irq_en_d;
    logic [31:0] rd_mux;

    // Any change of ms_in is one tick, including jumps and wraps.
    assign tick      = (ms_in != ms_prev);
    assign busy      = (state != IDLE);
    assign load_val  = (period == 32'd0) ? 32'd1 : period;
    assign wr_ctrl   = wr_en && (addr == A_CTRL);
    assign wr_period = wr_en && (addr == A_PERIOD);
    assign wr_status = wr_en && (addr == A_STATUS);

    // fired: set on FIRE beats a simultaneous write-1-to-clear.
    always_comb begin
        fired_d = fired;
        if (state == FIRE) begin
            fired_d = 1'b1;
        end else if (wr_status && wdata[0]) begin
            fired_d = 1'b0;
        end
    end

    always_comb begin
        irq_en_d = ctrl_irq_en;
        if (wr_ctrl) begin
            irq_en_d = wdata[2];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            A_CTRL:    rd_mux = {29'd0, ctrl_irq_en,
                                 ctrl_periodic, ctrl_en};
            A_PERIOD:  rd_mux = period;
            A_STATUS:  rd_mux = {30'd0, busy, fired};
            A_REMAIN:  rd_mux = remain;
`ifdef MS_ALARM_CAPTURE_EN
            A_CAPTURE: rd_mux = capture;
`else
            A_CAPTURE: rd_mux = 32'd0;
`endif
            default:   rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            period        <= RESET_PERIOD;
            fired         <= 1'b0;
            remain        <= 32'd0;
            ms_prev       <= ms_in;
            rdata         <= 32'd0;
            irq           <= 1'b0;
`ifdef MS_ALARM_CAPTURE_EN
            capture       <= 32'd0;
`endif
        end else begin
            ms_prev <= ms_in;
            rdata   <= rd_mux;
            fired   <= fired_d;
            // Uses next-cycle values so irq rises together with fired.
            irq     <= fired_d & irq_en_d;

            if (wr_period) begin
                period <= wdata;
            end

            case (state)
                IDLE: begin
                end
                ARMED: begin
                    if (tick) begin
                        if (remain <= 32'd1) begin
                            remain <= 32'd0;
                            state  <= FIRE;
                        end else begin
                            remain <= remain - 32'd1;
                        end
                    end
                end
                FIRE: begin
                    // Ticks in this cycle are dropped on purpose.
`ifdef MS_ALARM_CAPTURE_EN
                    capture <= ms_in;
`endif
                    if (ctrl_periodic) begin
                        remain <= load_val;
                        state  <= ARMED;
                    end else begin
                        ctrl_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A CTRL write overrides whatever the FSM chose above.
            if (wr_ctrl) begin
                ctrl_en       <= wdata[0];
                ctrl_periodic <= wdata[1];
                ctrl_irq_en   <= wdata[2];
                if (wdata[0]) begin
                    remain <= load_val;
                    state  <= ARMED;
                end else begin
                    remain <= remain;
                    state  <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ms_alarm_timer.sv
// tb_ms_alarm_timer: directed stimulus with a queued scoreboard.
// Stimulus pushes expected values; a monitor pops on each read response.

module tb_ms_alarm_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ms_in = 32'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic        rd_strobe = 1'b0;
    logic        rd_vld = 1'b0;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    int          m_kind;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;

`ifdef MS_ALARM_CAPTURE_EN
    localparam logic [31:0] CAP_EXP = 32'd42;
`else
    localparam logic [31:0] CAP_EXP = 32'd0;
`endif

    ms_alarm_timer dut (
        .clk   (clk),
        .rst   (rst),
        .ms_in (ms_in),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // A request issued before an edge is answered after that edge.
    always @(posedge clk) rd_vld <= rd_strobe;

    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty actual=none required=entry");
            end else begin
                m_kind = kind_q.pop_front();
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                m_act  = (m_kind == 1) ? {31'd0, irq} : rdata;
                if (m_act !== m_exp) begin
                    failures++;
                    $display("FAIL %s actual=%0d required=%0d",
                             m_name, m_act, m_exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e,
                      input string n);
        addr = a;
        kind_q.push_back(0);
        exp_q.push_back(e);
        name_q.push_back(n);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string n);
        kind_q.push_back(1);
        exp_q.push_back({31'd0, e});
        name_q.push_back(n);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    task automatic tick();
        ms_in = ms_in + 32'd1;
        cyc(20);
    endtask

    task automatic set_ms(input logic [31:0] v);
        ms_in = v;
        cyc(20);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        rst = 1'b0;

        // Reset state
        rd(3'd0, 32'd0, "rst_ctrl");
        rd(3'd1, 32'd1000, "rst_period");
        rd(3'd2, 32'd0, "rst_status");
        rd(3'd3, 32'd0, "rst_remain");
        chk_irq(1'b0, "rst_irq");

        // One-shot, PERIOD=3
        wr(3'd1, 32'd3);
        wr(3'd0, 32'd5);
        rd(3'd2, 32'd2, "os_busy");
        tick();
        tick();
        rd(3'd3, 32'd1, "os_remain1");
        ms_in = ms_in + 32'd1;
        chk_irq(1'b0, "os_irq_in_fire");
        chk_irq(1'b1, "os_irq_after_fire");
        rd(3'd0, 32'd4, "os_ctrl_en_clr");
        rd(3'd2, 32'd1, "os_status");
        rd(3'd3, 32'd0, "os_remain0");
        wr(3'd2, 32'd1);
        chk_irq(1'b0, "os_irq_w1c");
        rd(3'd2, 32'd0, "os_status_w1c");

        // Periodic, PERIOD=2
        wr(3'd1, 32'd2);
        wr(3'd0, 32'd7);
        tick();
        rd(3'd3, 32'd1, "per_remain1");
        tick();
        rd(3'd2, 32'd3, "per_fire2");
        chk_irq(1'b1, "per_irq2");
        wr(3'd2, 32'd1);
        chk_irq(1'b0, "per_irq_w1c");
        rd(3'd2, 32'd2, "per_busy");
        tick();
        tick();
        rd(3'd2, 32'd3, "per_fire4");
        wr(3'd2, 32'd1);
        tick();
        // Sixth tick fires; a tick during FIRE must not count.
        ms_in = ms_in + 32'd1;
        @(negedge clk);
        ms_in = ms_in + 32'd1;
        cyc(5);
        rd(3'd3, 32'd2, "per_fire_tick_ignored");
        rd(3'd2, 32'd3, "per_fire6");
        rd(3'd0, 32'd7, "per_ctrl");
        wr(3'd0, 32'd0);
        wr(3'd2, 32'd1);

        // PERIOD=0 behaves as 1
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd5);
        rd(3'd3, 32'd1, "p0_remain");
        rd(3'd1, 32'd0, "p0_period");
        tick();
        rd(3'd2, 32'd1, "p0_fired");
        wr(3'd2, 32'd1);

        // W1C coinciding with FIRE
        wr(3'd1, 32'd1);
        wr(3'd0, 32'd5);
        ms_in = ms_in + 32'd1;
        @(negedge clk);
        wr(3'd2, 32'd1);
        rd(3'd2, 32'd1, "w1c_fire_set_wins");
        wr(3'd2, 32'd1);

        // ms_in discontinuities
        set_ms(32'd100);
        wr(3'd1, 32'd10);
        wr(3'd0, 32'd5);
        set_ms(32'd105);
        rd(3'd3, 32'd9, "jump_one_tick");
        set_ms(32'd500);
        set_ms(32'd0);
        rd(3'd3, 32'd7, "wrap_one_tick");
        cyc(1000);
        rd(3'd3, 32'd7, "hold_no_tick");

        // Reset mid-countdown
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(3'd0, 32'd0, "mid_rst_ctrl");
        rd(3'd1, 32'd1000, "mid_rst_period");
        rd(3'd2, 32'd0, "mid_rst_status");
        rd(3'd3, 32'd0, "mid_rst_remain");
        chk_irq(1'b0, "mid_rst_irq");

        // Stop mid-countdown
        wr(3'd1, 32'd6);
        wr(3'd0, 32'd5);
        tick();
        tick();
        wr(3'd0, 32'd4);
        rd(3'd3, 32'd4, "stop_remain");
        rd(3'd2, 32'd0, "stop_status");
        tick();
        rd(3'd3, 32'd4, "stop_hold");

        // Restart and PERIOD write while armed
        wr(3'd0, 32'd5);
        tick();
        wr(3'd1, 32'd3);
        rd(3'd3, 32'd5, "armed_period_wr");
        wr(3'd0, 32'd5);
        rd(3'd3, 32'd3, "restart_reload");
        wr(3'd0, 32'd0);

        // Capture and unmapped addresses
        set_ms(32'd41);
        wr(3'd1, 32'd1);
        wr(3'd0, 32'd5);
        set_ms(32'd42);
        rd(3'd4, CAP_EXP, "capture");
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'd0, "unmapped5");
        rd(3'd7, 32'd0, "unmapped7");

        cyc(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ms_alarm_timer.md
MS_ALARM_TIMER -- requirements
Module: ms_alarm_timer

Interface
REQ-001 The module SHALL have parameter RESET_PERIOD, default 32'd1000, the PERIOD register value after reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge clk.
REQ-003 The module SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have port ms_in, input, 32 bits, the free-running millisecond count from the upstream millisecond counter.
REQ-005 The module SHALL have port wr_en, input, 1 bit, a register write strobe.
REQ-006 The module SHALL have port addr, input, 3 bits, the register address for both reads and writes.
REQ-007 The module SHALL have port wdata, input, 32 bits, the write data.
REQ-008 The module SHALL have port rdata, output, 32 bits, the registered read data.
REQ-009 The module SHALL have port irq, output, 1 bit, the interrupt request, level-sensitive.

Function
REQ-010 The register map SHALL be:
  - 0 CTRL: bit0 en, bit1 periodic, bit2 irq_en.
  - 1 PERIOD: 32 bits, read/write.
  - 2 STATUS: bit0 fired (write-1-to-clear), bit1 busy (read-only).
  - 3 REMAIN: read-only.
  - 4 CAPTURE: read-only.
  - 5-7: read 0; writes ignored.
REQ-011 rdata SHALL present the addressed register one cycle after addr is applied, on every cycle, with no read strobe.
REQ-012 A tick SHALL occur in any cycle where ms_in differs from its value registered on the previous cycle.
  - A jump of more than 1 counts as one tick.
  - A decrease (upstream counter reset) counts as one tick.
REQ-013 The FSM SHALL have three states: IDLE, ARMED, FIRE.
REQ-014 IDLE -> ARMED SHALL occur on a CTRL write with en=1.
  - REMAIN loads max(PERIOD,1) on that edge; PERIOD=0 is treated as 1.
REQ-015 In ARMED, each tick SHALL decrement REMAIN by 1.
  - A tick with REMAIN==1 sets REMAIN to 0 and moves to FIRE.
REQ-016 FIRE SHALL last exactly one cycle and set STATUS.fired.
  - periodic=1: reload REMAIN=max(PERIOD,1) and return to ARMED.
  - periodic=0: clear CTRL.en and go to IDLE.
REQ-017 A tick arriving during the FIRE cycle SHALL be ignored and not counted against the reloaded period.
REQ-018 A CTRL write with en=0 in any state SHALL go to IDLE on the next edge; REMAIN holds its value and fired is unchanged.
REQ-019 A CTRL write with en=1 while ARMED SHALL restart the countdown by reloading REMAIN.
REQ-020 A PERIOD write while ARMED SHALL take effect only at the next load or reload.
REQ-021 STATUS.busy SHALL equal 1 when the state is ARMED or FIRE.
REQ-022 irq SHALL equal STATUS.fired AND CTRL.irq_en, registered, asserting the cycle after FIRE.
REQ-023 If a W1C of fired coincides with a FIRE cycle, fired SHALL remain 1 (the set wins).
REQ-024 REMAIN SHALL never underflow; all arithmetic is 32-bit unsigned.

Reset
REQ-025 On rst=1 at a clock edge:
  - state = IDLE; CTRL = 0; PERIOD = RESET_PERIOD.
  - fired = 0; REMAIN = 0; CAPTURE = 0; rdata = 0; irq = 0.
  - The previous-ms register loads ms_in, so no spurious tick is generated.
REQ-026 Reset SHALL take priority over register writes and ticks, including when asserted mid-countdown.

Configuration
REQ-027 Macro MS_ALARM_CAPTURE_EN, when defined, SHALL make CAPTURE load ms_in on each FIRE cycle; CAPTURE reads that value.
REQ-028 Without MS_ALARM_CAPTURE_EN, CAPTURE SHALL not be implemented and address 4 SHALL read 0.

Verification
REQ-029 The bench SHALL cover one-shot operation:
  - Stimulus: PERIOD=3, CTRL=0b101, then ms_in increments every 20 cycles.
  - Response: FIRE on the 3rd tick; irq=1 the next cycle; en=0; busy=0; REMAIN=0.
REQ-030 The bench SHALL cover periodic operation:
  - Stimulus: PERIOD=2, CTRL=0b111, then 6 ticks.
  - Response: fired set at ticks 2, 4 and 6; W1C between fires clears irq; busy stays 1.
REQ-031 The bench SHALL cover the PERIOD=0 and simultaneous-event boundaries:
  - PERIOD=0 then start -> fires on the 1st tick.
  - W1C STATUS in the same cycle as FIRE -> fired stays 1.
REQ-032 The bench SHALL cover ms_in discontinuities:
  - ms_in jumps 100 -> 105 -> count decrements once.
  - ms_in goes 500 -> 0 -> one tick.
  - ms_in held constant for 1000 cycles -> no decrement.
REQ-033 The bench SHALL cover reset and stop mid-operation:
  - rst while ARMED with REMAIN=7 -> next cycle: all registers hold reset values, irq=0, PERIOD=1000.
  - CTRL en=0 write with REMAIN=4 -> IDLE, REMAIN reads 4.
REQ-034 The bench SHALL cover capture, with MS_ALARM_CAPTURE_EN defined:
  - Stimulus: one-shot PERIOD=1 with ms_in 41 -> 42.
  - Response: CAPTURE reads 42.
  - With the macro undefined, address 4 reads 0.
